// File: rtl/rib_sram_pkg.sv
// Shared RIB definitions: transfer direction constants and the response FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a. Optional macro RIB_SRAM_WAIT_EN adds the WAIT state encoding.
package rib_sram_pkg;

    localparam logic RIB_WR = 1'b1;
    localparam logic RIB_RD = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RESP = 2'd1
`ifdef RIB_SRAM_WAIT_EN
        , ST_WAIT = 2'd2
`endif
    } rib_state_e;

endpackage

// File: rtl/sram_1rw_be.sv
// Synchronous single-port 32-bit SRAM with per-byte write enables, shaped for block-RAM inference.
// Latency: read data appears one cycle after an enabled read; writes commit at the clock edge.
// Backpressure: none; read data register holds its value until the next enabled read.
module sram_1rw_be #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane writes; contents are intentionally never reset
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Registered read port, only updated by reads so it holds during a stalled response
    always_ff @(posedge clk_i) begin
        if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/rib_sram.sv
// RIB slave wrapping a byte-enabled SRAM; one transaction outstanding at a time.
// Latency: accept in cycle N -> rsp in N+1 (N+WAIT_CYCLES+1 with macro RIB_SRAM_WAIT_EN defined).
// Backpressure: rsp/rdata held while i_ribs_rdy is low; gnt in RESP mirrors i_ribs_rdy for back-to-back.
module rib_sram
    import rib_sram_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [31:0] i_ribs_addr,
    input  logic        i_ribs_wrcs,
    input  logic [3:0]  i_ribs_mask,
    input  logic [31:0] i_ribs_wdata,
    output logic [31:0] o_ribs_rdata,
    input  logic        i_ribs_req,
    output logic        o_ribs_gnt,
    output logic        o_ribs_rsp,
    input  logic        i_ribs_rdy
);

    localparam int AW = $clog2(DEPTH_WORDS);

`ifdef RIB_SRAM_WAIT_EN
    localparam rib_state_e ACC_STATE = ST_WAIT;
`else
    localparam rib_state_e ACC_STATE = ST_RESP;
    localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

    rib_state_e    state_q, state_d;
    logic          rd_q, rd_d;
    logic          accept;
    logic [AW-1:0] word_idx;
    logic [31:0]   sram_rdata;
    logic          unused_addr;

    // Word index; byte offset and bits above the array size alias away
    assign word_idx    = i_ribs_addr[AW+1:2];
    assign unused_addr = ^{i_ribs_addr[31:AW+2], i_ribs_addr[1:0]};
    assign accept      = i_ribs_req & o_ribs_gnt;

`ifdef RIB_SRAM_WAIT_EN
    logic [3:0] cnt_q, cnt_d;

    // Wait counter: load on accept, count down to zero while in WAIT
    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = 4'(WAIT_CYCLES - 1);
        end else if (state_q == ST_WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // Wait counter register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: accept goes to RESP (or WAIT); RESP drains to IDLE or chains the next request
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ACC_STATE;
            end
            ST_RESP: begin
                if (i_ribs_rdy) state_d = i_ribs_req ? ACC_STATE : ST_IDLE;
            end
`ifdef RIB_SRAM_WAIT_EN
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: gnt from state and rdy only, rsp/rdata purely from registered state
    always_comb begin
        o_ribs_gnt   = 1'b0;
        o_ribs_rsp   = 1'b0;
        o_ribs_rdata = '0;
        case (state_q)
            ST_IDLE: o_ribs_gnt = 1'b1;
            ST_RESP: begin
                o_ribs_gnt = i_ribs_rdy;
                o_ribs_rsp = 1'b1;
                if (rd_q) o_ribs_rdata = sram_rdata;
            end
            default: ;
        endcase
    end

    // Remember whether the in-flight transaction is a read so write responses return zero
    always_comb begin
        rd_d = rd_q;
        if (accept) rd_d = (i_ribs_wrcs == RIB_RD);
    end

    // Read-flag register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
        end
    end

    sram_1rw_be #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_mem (
        .clk_i   (i_clk),
        .en_i    (accept),
        .we_i    (i_ribs_wrcs == RIB_WR),
        .be_i    (i_ribs_mask),
        .addr_i  (word_idx),
        .wdata_i (i_ribs_wdata),
        .rdata_o (sram_rdata)
    );

endmodule
